eth_rx_buf_writer: RTL

- Stream-to-buffer writer on the FPGA-logic side of the shared 2 KB rx/tx dual-port buffer.
- Accepts a byte stream with packet framing and writes each frame's payload through the buffer's second port (11-bit address, 8-bit data).
- Prepends a 2-byte length header, then raises a level interrupt toward the Nios ethernet input IRQ and holds until the CPU acknowledges.
- Stalls the stream while a frame awaits CPU service. Drops oversize or malformed frames.

---
 rtl/eth_buf_pkg.sv | 20 ++
 rtl/eth_sat_counter.sv | 23 ++
 rtl/eth_rx_buf_writer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/eth_buf_pkg.sv
// Shared types and constants for the ethernet rx stream-to-buffer writer.
// The header occupies the first two buffer bytes; the payload follows it.
package eth_buf_pkg;

    localparam int BUF_AW_DEF  = 11;
    localparam int MAX_LEN_DEF = 2046;
    localparam int HDR_BYTES   = 2;
    localparam int HDR_HI_ADDR = 0;
    localparam int HDR_LO_ADDR = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_NOTIFY,
        ST_DISCARD
    } eth_bw_state_t;

endpackage

// File: rtl/eth_sat_counter.sv
// Saturating up-counter: it holds at all-ones instead of wrapping.
module eth_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/eth_rx_buf_writer.sv
// Writes framed stream bytes into the shared rx buffer behind a 2-byte length
// header, then raises irq_eth and stalls the stream until the CPU acknowledges.
module eth_rx_buf_writer
    import eth_buf_pkg::*;
#(
    parameter int BUF_AW  = BUF_AW_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        st_data,
    input  logic              st_valid,
    input  logic              st_sop,
    input  logic              st_eop,
    output logic              st_ready,
    output logic [BUF_AW-1:0] buf_address,
    output logic              buf_chipselect,
    output logic              buf_clken,
    output logic              buf_write,
    output logic [7:0]        buf_writedata,
    output logic              irq_eth,
    input  logic              cpu_ack,
    output logic [BUF_AW-1:0] frame_len,
    output logic              busy,
    output logic [CNT_W-1:0]  drop_count
);

    localparam logic [BUF_AW-1:0] HDR_BASE  = BUF_AW'(HDR_BYTES);
    localparam logic [BUF_AW-1:0] MAX_LEN_C = BUF_AW'(MAX_LEN);
    localparam logic [BUF_AW-1:0] HI_ADDR   = BUF_AW'(HDR_HI_ADDR);
    localparam logic [BUF_AW-1:0] LO_ADDR   = BUF_AW'(HDR_LO_ADDR);

    eth_bw_state_t     state_reg;
    logic [BUF_AW-1:0] count_reg;
    logic              ready_reg;
    logic              buf_write_reg;
    logic [BUF_AW-1:0] buf_address_reg;
    logic [7:0]        buf_writedata_reg;
    logic              irq_reg;
    logic [BUF_AW-1:0] frame_len_reg;

    logic beat;
    logic drop_inc;

    assign beat = st_valid && ready_reg;

    // A frame is dropped on a missing eop (sop seen mid-frame) or on overflow.
    assign drop_inc = beat && (state_reg == ST_DATA) && (st_sop || (count_reg == MAX_LEN_C));

    eth_sat_counter #(
        .W(CNT_W)
    ) u_drop_counter (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (drop_inc),
        .count  (drop_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= ST_IDLE;
            count_reg         <= '0;
            ready_reg         <= 1'b0;
            buf_write_reg     <= 1'b0;
            buf_address_reg   <= '0;
            buf_writedata_reg <= '0;
            irq_reg           <= 1'b0;
            frame_len_reg     <= '0;
        end else begin
            buf_write_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    ready_reg <= 1'b1;
                    if (beat && st_sop) begin
                        buf_write_reg     <= 1'b1;
                        buf_address_reg   <= HDR_BASE;
                        buf_writedata_reg <= st_data;
                        count_reg         <= BUF_AW'(1);
                        if (st_eop) begin
                            state_reg <= ST_HDR_HI;
                            ready_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        if (st_sop) begin
                            // Restart: this beat becomes byte 0 of a new frame.
                            buf_write_reg     <= 1'b1;
                            buf_address_reg   <= HDR_BASE;
                            buf_writedata_reg <= st_data;
                            count_reg         <= BUF_AW'(1);
                            if (st_eop) begin
                                state_reg <= ST_HDR_HI;
                                ready_reg <= 1'b0;
                            end
                        end else if (count_reg < MAX_LEN_C) begin
                            buf_write_reg     <= 1'b1;
                            buf_address_reg   <= HDR_BASE + count_reg;
                            buf_writedata_reg <= st_data;
                            count_reg         <= count_reg + 1'b1;
                            if (st_eop) begin
                                state_reg <= ST_HDR_HI;
                                ready_reg <= 1'b0;
                            end
                        end else begin
                            state_reg <= st_eop ? ST_IDLE : ST_DISCARD;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (beat && st_eop) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_HDR_HI: begin
                    buf_write_reg     <= 1'b1;
                    buf_address_reg   <= HI_ADDR;
                    buf_writedata_reg <= 8'(count_reg >> 8);
                    state_reg         <= ST_HDR_LO;
                end
                ST_HDR_LO: begin
                    buf_write_reg     <= 1'b1;
                    buf_address_reg   <= LO_ADDR;
                    buf_writedata_reg <= count_reg[7:0];
                    frame_len_reg     <= count_reg;
                    state_reg         <= ST_NOTIFY;
                end
                ST_NOTIFY: begin
                    if (cpu_ack) begin
                        irq_reg   <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        irq_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign st_ready       = ready_reg;
    assign buf_address    = buf_address_reg;
    assign buf_write      = buf_write_reg;
    assign buf_chipselect = buf_write_reg;
    assign buf_writedata  = buf_writedata_reg;
    assign buf_clken      = 1'b1;
    assign irq_eth        = irq_reg;
    assign frame_len      = frame_len_reg;
    assign busy           = (state_reg != ST_IDLE);

endmodule
